// File: rtl/reg_stream_fifo.sv
// First-word-fall-through elastic buffer behind the 16-bit register stage.
// Optional same-cycle bypass when empty: define REG_STREAM_FIFO_BYPASS_EN.
module reg_stream_fifo #(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_valid,
  output logic                       I_ready,
  output logic [WIDTH-1:0]           O,
  output logic                       O_valid,
  input  logic                       O_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_enq;
  logic w_deq;

  // Full/empty come only from the occupancy counter, so pointers may wrap freely.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL);
  assign I_ready = !RESET && !w_full;
  assign count   = r_count;

`ifdef REG_STREAM_FIFO_BYPASS_EN
  logic w_bypass;

  // An empty buffer forwards the incoming word; it is only stored if the consumer stalls.
  assign w_bypass = w_empty && I_valid && !RESET;
  assign O_valid  = !w_empty || w_bypass;
  assign O        = w_bypass ? I : r_mem[r_rdPtr];
  assign w_enq    = I_valid && I_ready && !(w_bypass && O_ready);
`else
  assign O_valid  = !w_empty;
  assign O        = r_mem[r_rdPtr];
  assign w_enq    = I_valid && I_ready;
`endif

  assign w_deq = !w_empty && O_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= INIT;
      end
    end else begin
      if (w_enq) begin
        r_mem[r_wrPtr] <= I;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_deq) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CW'(1);
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_stream_fifo.sv
// Scoreboard bench for reg_stream_fifo: accepted words are queued, a monitor pops
// and compares on every output handshake; directed cases plus randomized traffic.
module tb_reg_stream_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             CLK     = 1'b0;
  logic             RESET   = 1'b1;
  logic [WIDTH-1:0] I       = '0;
  logic             I_valid = 1'b0;
  logic             O_ready = 1'b0;
  logic             I_ready;
  logic [WIDTH-1:0] O;
  logic             O_valid;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sbQ[$];

  reg_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT('0)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .I_valid(I_valid), .I_ready(I_ready),
    .O(O), .O_valid(O_valid), .O_ready(O_ready), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, so they are stable for the next edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [WIDTH-1:0] d, input logic r);
    @(posedge CLK);
    #1;
    RESET   = rst;
    I_valid = v;
    I       = d;
    O_ready = r;
  endtask

  task automatic drainAll(input string name);
    for (int k = 0; k < 20 && count != '0; k++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput(name, 32'(count), 32'd0);
  endtask

  // Reference: stored words are exactly the accepted-but-not-yet-consumed queue.
  always @(negedge CLK) begin
    if (RESET) begin
      sbQ.delete();
    end else begin
      checkOutput("count", 32'(count), 32'(sbQ.size()));
      checkOutput("iReady", 32'(I_ready), 32'(sbQ.size() != DEPTH));
`ifdef REG_STREAM_FIFO_BYPASS_EN
      checkOutput("oValid", 32'(O_valid), 32'((sbQ.size() != 0) || I_valid));
`else
      checkOutput("oValid", 32'(O_valid), 32'(sbQ.size() != 0));
`endif
      if (I_valid && I_ready) sbQ.push_back(I);
    end
  end

  always @(negedge CLK) begin
    logic [WIDTH-1:0] expWord;
    #1;
    if (!RESET && O_valid && O_ready) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWord got %0h expected none", O);
      end else begin
        expWord = sbQ.pop_front();
        checkOutput("order", 32'(O), 32'(expWord));
      end
    end
  end

  initial begin
    logic             v;
    logic             r;
    logic             rst;
    logic             hold;
    logic [WIDTH-1:0] d;
    int               idx;
    int               maxCnt;

    // Reset, then idle.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    #1;
    checkOutput("iReadyInReset", 32'(I_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("resetO", 32'(O), 32'h0000);
    checkOutput("resetOValid", 32'(O_valid), 32'd0);
    checkOutput("resetIReady", 32'(I_ready), 32'd1);
    checkOutput("resetCount", 32'(count), 32'd0);

    // Single word.
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("singleO", 32'(O), 32'hBEEF);
    checkOutput("singleOValid", 32'(O_valid), 32'd1);
    checkOutput("singleCount", 32'(count), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("singleDrainCount", 32'(count), 32'd0);
    checkOutput("singleDrainOValid", 32'(O_valid), 32'd0);

    // Fill to full; a dequeue on a full cycle must not admit a new word.
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b1, 16'(k), 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0005, 1'b1);
    #1;
    checkOutput("fullCount", 32'(count), 32'd4);
    checkOutput("fullIReady", 32'(I_ready), 32'd0);
    checkOutput("fullHead", 32'(O), 32'h0001);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("fullDeqCount", 32'(count), 32'd3);
    checkOutput("fullDeqHead", 32'(O), 32'h0002);
    drainAll("fullDrain");

    // Wrap-around stream with toggling consumer.
    idx = 0;
    maxCnt = 0;
    for (int n = 0; n < 100 && idx < 12; n++) begin
      applyStimulus(1'b0, 1'b1, 16'h0010 + 16'(idx), (n % 2) == 0);
      #1;
      if (I_ready) idx++;
      if (int'(count) > maxCnt) maxCnt = int'(count);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("wrapAllSent", 32'(idx), 32'd12);
    checkOutput("wrapMaxLe4", 32'(maxCnt <= 4), 32'd1);
    drainAll("wrapDrain");

    // Simultaneous enqueue and dequeue at count 2.
    applyStimulus(1'b0, 1'b1, 16'h0021, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0022, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0023, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("simulCount", 32'(count), 32'd2);
    checkOutput("simulHead", 32'(O), 32'h0022);
    drainAll("simulDrain");

    // Reset with three words stored.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 16'h0031 + 16'(k), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("preResetCount", 32'(count), 32'd3);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("midResetCount", 32'(count), 32'd0);
    checkOutput("midResetOValid", 32'(O_valid), 32'd0);
    checkOutput("midResetO", 32'(O), 32'h0000);
    applyStimulus(1'b0, 1'b1, 16'hA5A5, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("postResetHead", 32'(O), 32'hA5A5);
    checkOutput("postResetCount", 32'(count), 32'd1);
    drainAll("postResetDrain");

`ifdef REG_STREAM_FIFO_BYPASS_EN
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1);
    #1;
    checkOutput("bypassO", 32'(O), 32'h1234);
    checkOutput("bypassOValid", 32'(O_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("bypassCount", 32'(count), 32'd0);
`endif

    // Random traffic: first half mostly stalled, second half mostly draining.
    hold = 1'b0;
    v = 1'b0;
    d = '0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!hold) begin
        v = 1'($urandom_range(0, 1));
        d = 16'($urandom);
      end
      r = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus(rst, v, d, r);
      #1;
      hold = !rst && v && !I_ready;
    end
    drainAll("randomDrain");
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
